fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_pkg.sv | 44 ++++
 rtl/fnd_bcd_to_seg.sv | 27 ++
 rtl/fnd_scan_controller.sv | 82 ++++++++
 tb/tb_fnd_scan_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit seven-segment scan display: active-low
// segment codes, one-cold digit enables and the digit-slot encoding.
package fnd_pkg;

    // Segment byte layout: bit7 = dp, bits6..0 = g,f,e,d,c,b,a (active-low).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] COM_DIG0 = 4'b1110;
    localparam logic [3:0] COM_DIG1 = 4'b1101;
    localparam logic [3:0] COM_DIG2 = 4'b1011;
    localparam logic [3:0] COM_DIG3 = 4'b0111;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        DIG_ONES      = 2'd0,
        DIG_TENS      = 2'd1,
        DIG_HUNDREDS  = 2'd2,
        DIG_THOUSANDS = 2'd3
    } digit_sel_e;

    function automatic logic [3:0] com_pattern(input digit_sel_e sel);
        logic [3:0] com;
        case (sel)
            DIG_ONES:      com = COM_DIG0;
            DIG_TENS:      com = COM_DIG1;
            DIG_HUNDREDS:  com = COM_DIG2;
            DIG_THOUSANDS: com = COM_DIG3;
            default:       com = COM_DIG0;
        endcase
        return com;
    endfunction

endpackage

// File: rtl/fnd_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decode; any code
// above 9 turns the digit fully off.
module fnd_bcd_to_seg
    import fnd_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Latches a binary value and time-multiplexes its four decimal digits onto a
// common-anode display. Define FND_LEADING_ZERO_BLANK_EN to blank leading zeros.
module fnd_scan_controller #(
    parameter int WIDTH    = 9,
    parameter int SCAN_DIV = 100_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sum,
    input  logic             sum_valid,
    output logic [7:0]       fnd_data,
    output logic [3:0]       fnd_com
);
    import fnd_pkg::*;

    localparam int              CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    digit_sel_e       digit_sel_q, digit_sel_d;
    logic [WIDTH-1:0] disp_val_q, disp_val_d;
    logic             tick;

    logic [13:0]      val_ext;
    logic [3:0]       digits [4];
    logic             blank_lead;
    logic [3:0]       bcd_sel;

    // Slot timing and capture share one edge, so a capture coinciding with a
    // tick is already visible in the newly selected slot.
    always_comb begin
        tick        = (scan_cnt_q == CNT_LAST);
        scan_cnt_d  = tick ? '0 : scan_cnt_q + CNT_W'(1);
        digit_sel_d = tick ? digit_sel_e'(digit_sel_q + 2'd1) : digit_sel_q;
        disp_val_d  = sum_valid ? sum : disp_val_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            digit_sel_q <= DIG_ONES;
            disp_val_q  <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_sel_q <= digit_sel_d;
            disp_val_q  <= disp_val_d;
        end
    end

    // WIDTH is at most 13, so the value never exceeds 8191 and four digits suffice.
    always_comb begin
        val_ext   = 14'(disp_val_q);
        digits[0] = 4'(val_ext % 14'd10);
        digits[1] = 4'((val_ext / 14'd10) % 14'd10);
        digits[2] = 4'((val_ext / 14'd100) % 14'd10);
        digits[3] = 4'((val_ext / 14'd1000) % 14'd10);
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    // Digit k is a leading zero exactly when the value is below 10^k.
    always_comb begin
        blank_lead = 1'b0;
        case (digit_sel_q)
            DIG_TENS:      blank_lead = (val_ext < 14'd10);
            DIG_HUNDREDS:  blank_lead = (val_ext < 14'd100);
            DIG_THOUSANDS: blank_lead = (val_ext < 14'd1000);
            default:       blank_lead = 1'b0;
        endcase
    end
`else
    assign blank_lead = 1'b0;
`endif

    assign bcd_sel = blank_lead ? BCD_BLANK : digits[digit_sel_q];
    assign fnd_com = com_pattern(digit_sel_q);

    fnd_bcd_to_seg u_bcd_to_seg (
        .bcd_i (bcd_sel),
        .seg_o (fnd_data)
    );

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed plus random checks of fnd_scan_controller against a cycle-count /
// decimal-arithmetic model of the scanned display (SCAN_DIV = 4).
module tb_fnd_scan_controller;

  localparam int WIDTH    = 9;
  localparam int SCAN_DIV = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] sum;
  logic             sum_valid;
  logic [7:0]       fnd_data;
  logic [3:0]       fnd_com;

  int errors;
  int checks;

  // Model state: edges counted since reset release and the captured value.
  int edges;
  int m_val;

  int          pow10   [4];
  logic [7:0]  seg_tab [10];

  fnd_scan_controller #(
    .WIDTH    (WIDTH),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sum       (sum),
    .sum_valid (sum_valid),
    .fnd_data  (fnd_data),
    .fnd_com   (fnd_com)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_slot();
    return (edges / SCAN_DIV) % 4;
  endfunction

  function automatic logic [3:0] model_com();
    logic [3:0] one_hot;
    one_hot = 4'b0001 << model_slot();
    return ~one_hot;
  endfunction

  function automatic logic [7:0] model_data();
    int slot;
    int dig;
    slot = model_slot();
    dig  = (m_val / pow10[slot]) % 10;
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (slot > 0 && m_val < pow10[slot]) return 8'hFF;
`endif
    return seg_tab[dig];
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check8({tag, "_com"}, {4'b0, fnd_com}, {4'b0, model_com()});
    check8({tag, "_data"}, fnd_data, model_data());
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) begin
      edges++;
      if (sum_valid) m_val = int'(sum);
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    pow10   = '{1, 10, 100, 1000};
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    errors = 0;
    checks = 0;
    edges  = 0;
    m_val  = 0;

    // Reset state
    reset = 1'b1;
    sum = '0;
    sum_valid = 1'b0;
    #2;
    check8("rst_com", {4'b0, fnd_com}, 8'h0E);
    check8("rst_data", fnd_data, 8'hC0);
    step("in_rst");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step("after_rst");

    // 123: ones=3, tens=2, hundreds=1, thousands=0
    sum = 9'd123;
    sum_valid = 1'b1;
    step("cap123");
    sum_valid = 1'b0;
    for (int i = 0; i < 32; i++) step("scan123");

    // 511: 1,1,5,0
    sum = 9'd511;
    sum_valid = 1'b1;
    step("cap511");
    sum_valid = 1'b0;
    for (int i = 0; i < 16; i++) step("scan511");

    // Hold: 45 captured, then 300 presented without strobe
    sum = 9'd45;
    sum_valid = 1'b1;
    step("cap45");
    sum_valid = 1'b0;
    sum = 9'd300;
    for (int i = 0; i < 32; i++) step("hold45");

    // Capture coinciding with a tick edge
    for (int i = 0; i < SCAN_DIV && (edges % SCAN_DIV) != SCAN_DIV - 1; i++) step("align7");
    sum = 9'd7;
    sum_valid = 1'b1;
    step("coin7");
    sum_valid = 1'b0;
    for (int i = 0; i < 16; i++) step("scan7");

    // Zero value on a tick edge
    for (int i = 0; i < SCAN_DIV && (edges % SCAN_DIV) != SCAN_DIV - 1; i++) step("align0");
    sum = 9'd0;
    sum_valid = 1'b1;
    step("coin0");
    sum_valid = 1'b0;
    for (int i = 0; i < 16; i++) step("scan0");

    // Random values and strobes, including held strobes
    for (int i = 0; i < 300; i++) begin
      sum = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      sum_valid = ($urandom_range(0, 3) == 0);
      step("rand");
    end
    sum_valid = 1'b0;

    // Mid-slot reset while digit 2 is selected
    for (int i = 0; i < 64 && !(model_slot() == 2 && (edges % SCAN_DIV) == 1); i++) step("seek2");
    check8("pre_rst_com", {4'b0, fnd_com}, 8'h0B);
    #2;
    reset = 1'b1;
    edges = 0;
    m_val = 0;
    #1;
    check8("mid_rst_com", {4'b0, fnd_com}, 8'h0E);
    check8("mid_rst_data", fnd_data, 8'hC0);
    step("mid_rst_hold");
    step("mid_rst_hold");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("post_rst");
      check8("post_rst_slot0", {4'b0, fnd_com}, 8'h0E);
    end
    step("post_rst");
    check8("post_rst_first_tick", {4'b0, fnd_com}, 8'h0D);
    for (int i = 0; i < 16; i++) step("post_rst_scan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
